// File: rtl/diag_func_seq_pkg.sv
// Shared types and widths for the EBUS diagnostic-function sequencer.
package diag_func_seq_pkg;

  localparam int DIAG_FUNC_W = 7;
  localparam int EBUS_DATA_W = 36;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } diag_seq_state_t;

endpackage

// File: rtl/diag_func_seq_rr_arb2.sv
// Two-way round-robin arbiter. The pointer always ends up on the requester
// that was not granted, so a contended pair alternates.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [0:1] req,
  output logic [0:1] grant
);

  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0] && req[1]) begin
        grant[ptr_q] = 1'b1;
      end else begin
        grant = req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (grant[0]) begin
      ptr_q <= 1'b1;
    end else if (grant[1]) begin
      ptr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/diag_func_seq.sv
// Diagnostic-function sequencer: arbitrates two requesters and runs each
// EBUS diagnostic function as a timed setup / strobe / hold cycle.
module diag_func_seq
  import diag_func_seq_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:1]             req_valid,
  output logic [0:1]             req_ready,
  input  logic [0:DIAG_FUNC_W-1] req0_func,
  input  logic [0:EBUS_DATA_W-1] req0_data,
  input  logic [0:DIAG_FUNC_W-1] req1_func,
  input  logic [0:EBUS_DATA_W-1] req1_data,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic [0:EBUS_DATA_W-1] rsp_data,
  output logic [0:DIAG_FUNC_W-1] ebus_ds,
  output logic [0:EBUS_DATA_W-1] ebus_data_out,
  output logic                   ebus_data_oe,
  output logic                   ebus_diag_strobe,
  input  logic [0:EBUS_DATA_W-1] ebus_data_in,
  output logic                   busy
);

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = (HOLD_CYC == 0) ? 4'd0 : 4'(HOLD_CYC - 1);

  diag_seq_state_t        state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [0:1]             ready_q, ready_d;
  logic [0:DIAG_FUNC_W-1] func_q, func_d;
  logic [0:EBUS_DATA_W-1] data_q, data_d;
  logic [0:EBUS_DATA_W-1] rsp_q, rsp_d;
  logic                   id_q, id_d;
  logic                   rd_q, rd_d;
  logic                   arb_en;
  logic [0:1]             grant;
  logic [0:DIAG_FUNC_W-1] sel_func;
  logic [0:EBUS_DATA_W-1] sel_data;
  logic                   active;

  // Arbitrate in IDLE (when no grant is outstanding) and in RESP, so the
  // registered ready lands in the first IDLE cycle after a response.
  assign arb_en = ((state_q == IDLE) && (ready_q == 2'b00)) || (state_q == RESP);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (reset),
    .en    (arb_en),
    .req   (req_valid),
    .grant (grant)
  );

  assign sel_func = ready_q[1] ? req1_func : req0_func;
  assign sel_data = ready_q[1] ? req1_data : req0_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 2'b00;
    func_d  = func_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    id_d    = id_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (ready_q != 2'b00) begin
          func_d  = sel_func;
          data_d  = sel_data;
          id_d    = ready_q[1];
          rd_d    = sel_func[0];
          rsp_d   = '0;
          cnt_d   = SETUP_LOAD;
          state_d = SETUP;
        end else begin
          ready_d = grant;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = STROBE_LOAD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          if (rd_q) begin
            rsp_d = ebus_data_in;
          end
          if (HOLD_CYC == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        ready_d = grant;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 2'b00;
      func_q  <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      id_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      func_q  <= func_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      id_q    <= id_d;
      rd_q    <= rd_d;
    end
  end

  // Bus outputs decode only registered state, so reset clears them at once.
  assign active           = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
  assign ebus_ds          = active ? func_q : '0;
  assign ebus_data_oe     = active && !rd_q;
  assign ebus_data_out    = (active && !rd_q) ? data_q : '0;
  assign ebus_diag_strobe = (state_q == STROBE);
  assign rsp_valid        = (state_q == RESP);
  assign rsp_id           = id_q;
  assign rsp_data         = rsp_q;
  assign busy             = (state_q != IDLE);
  assign req_ready        = ready_q;

endmodule

// File: tb/tb_diag_func_seq.sv
// Directed bench for diag_func_seq: default timing instance plus a
// minimum-timing instance for the parameter corner.
module tb_diag_func_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  req_valid, req_ready;
  logic [0:6]  req0_func, req1_func, ebus_ds;
  logic [0:35] req0_data, req1_data, rsp_data, ebus_data_out, ebus_data_in;
  logic        rsp_valid, rsp_id, ebus_data_oe, ebus_diag_strobe, busy;

  logic [0:1]  c_req_valid, c_req_ready;
  logic [0:6]  c_req0_func, c_req1_func, c_ebus_ds;
  logic [0:35] c_req0_data, c_req1_data, c_rsp_data, c_ebus_data_out, c_ebus_data_in;
  logic        c_rsp_valid, c_rsp_id, c_ebus_data_oe, c_ebus_diag_strobe, c_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  diag_func_seq dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req0_func(req0_func), .req0_data(req0_data), .req1_func(req1_func), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .ebus_ds(ebus_ds),
    .ebus_data_out(ebus_data_out), .ebus_data_oe(ebus_data_oe),
    .ebus_diag_strobe(ebus_diag_strobe), .ebus_data_in(ebus_data_in), .busy(busy)
  );

  diag_func_seq #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(0)) dut_min (
    .clk(clk), .reset(reset), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req0_func(c_req0_func), .req0_data(c_req0_data), .req1_func(c_req1_func), .req1_data(c_req1_data),
    .rsp_valid(c_rsp_valid), .rsp_id(c_rsp_id), .rsp_data(c_rsp_data), .ebus_ds(c_ebus_ds),
    .ebus_data_out(c_ebus_data_out), .ebus_data_oe(c_ebus_data_oe),
    .ebus_diag_strobe(c_ebus_diag_strobe), .ebus_data_in(c_ebus_data_in), .busy(c_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit corner, output logic [0:1] g);
    g = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      g = corner ? c_req_ready : req_ready;
      if (g !== 2'b00) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0; req0_func = '0; req1_func = '0; req0_data = '0; req1_data = '0;
    c_req_valid = '0; c_req0_func = '0; c_req1_func = '0; c_req0_data = '0; c_req1_data = '0;
    ebus_data_in = '0; c_ebus_data_in = '0;
    repeat (2) tick();
    checks++; if (ebus_ds !== 7'o000) begin errors++; $display("FAIL reset_ds got %o exp 000", ebus_ds); end
    checks++; if ({ebus_data_oe, ebus_diag_strobe, rsp_valid, rsp_id, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl got oe/stb/rv/id/busy=%b exp 00000",
                         {ebus_data_oe, ebus_diag_strobe, rsp_valid, rsp_id, busy}); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    checks++; if ({rsp_data, ebus_data_out} !== 72'd0) begin
      errors++; $display("FAIL reset_data got rsp %o out %o exp 0", rsp_data, ebus_data_out); end
    @(negedge clk) reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset got busy %b ready %b exp 0 00", busy, req_ready); end
    $display("reset: done");
  endtask

  task automatic test_write();
    logic [0:35] wd;
    logic [0:1]  g;
    logic [0:6]  exp_ds;
    wd = '0;
    wd[24:27] = 4'b1010;
    req0_func = 7'o076; req0_data = wd; req_valid[0] = 1'b1;
    wait_ready(1'b0, g);
    checks++; if (g !== 2'b10) begin errors++; $display("FAIL write_grant got %b exp 10", g); end
    req_valid = '0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) begin
        checks++; if (ebus_data_out !== wd) begin errors++; $display("FAIL write_data got %o exp %o", ebus_data_out, wd); end
        req0_func = 7'o177; req0_data = '1;
      end
      exp_ds = (k <= 6) ? 7'o076 : 7'o000;
      checks++; if (ebus_ds !== exp_ds) begin errors++; $display("FAIL write_ds k=%0d got %o exp %o", k, ebus_ds, exp_ds); end
      checks++; if (ebus_data_oe !== (k <= 6)) begin errors++; $display("FAIL write_oe k=%0d got %b", k, ebus_data_oe); end
      checks++; if (ebus_diag_strobe !== (k >= 3 && k <= 5)) begin
        errors++; $display("FAIL write_strobe k=%0d got %b", k, ebus_diag_strobe); end
      checks++; if (rsp_valid !== (k == 7)) begin errors++; $display("FAIL write_rsp_valid k=%0d got %b", k, rsp_valid); end
    end
    checks++; if (rsp_id !== 1'b0 || rsp_data !== 36'd0) begin
      errors++; $display("FAIL write_rsp got id %b data %o exp 0 0", rsp_id, rsp_data); end
    $display("write: func 076 id 0 rsp_data %o", rsp_data);
  endtask

  task automatic test_read();
    logic [0:1] g;
    req1_func = 7'o100; req1_data = '1; req_valid[1] = 1'b1;
    ebus_data_in = 36'o555555555555;
    wait_ready(1'b0, g);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL read_grant got %b exp 01", g); end
    req_valid = '0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) req1_func = 7'o000;
      if (k == 5) ebus_data_in = 36'o123456701234;
      if (k == 6) ebus_data_in = 36'o555555555555;
      checks++; if (ebus_data_oe !== 1'b0 || ebus_data_out !== 36'd0) begin
        errors++; $display("FAIL read_oe k=%0d got oe %b out %o exp 0", k, ebus_data_oe, ebus_data_out); end
      checks++; if (ebus_ds !== ((k <= 6) ? 7'o100 : 7'o000)) begin
        errors++; $display("FAIL read_ds k=%0d got %o", k, ebus_ds); end
      checks++; if (rsp_valid !== (k == 7)) begin errors++; $display("FAIL read_rsp_valid k=%0d got %b", k, rsp_valid); end
    end
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL read_rsp_id got %b exp 1", rsp_id); end
    checks++; if (rsp_data !== 36'o123456701234) begin
      errors++; $display("FAIL read_rsp_data got %o exp 123456701234", rsp_data); end
    ebus_data_in = '0;
    $display("read: func 100 id %0d rsp_data %o", rsp_id, rsp_data);
  endtask

  task automatic test_simultaneous();
    int ng, last_rsp;
    logic last_id;
    logic [0:1] exp_g;
    ng = 0; last_rsp = -10; last_id = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk) reset = 1'b0;
    req0_func = 7'o040; req1_func = 7'o041; req0_data = '0; req1_data = '0;
    req_valid = 2'b11;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      tick();
      if (rsp_valid) begin
        last_rsp = c;
        checks++; if (rsp_id !== last_id) begin errors++; $display("FAIL sim_rsp_id c=%0d got %b exp %b", c, rsp_id, last_id); end
      end
      if (req_ready !== 2'b00) begin
        exp_g = 2'b00;
        exp_g[ng % 2] = 1'b1;
        checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL sim_grant n=%0d got %b exp %b", ng, req_ready, exp_g); end
        if (ng > 0) begin
          checks++; if (c != last_rsp + 1) begin
            errors++; $display("FAIL sim_b2b n=%0d grant cycle %0d exp %0d", ng, c, last_rsp + 1); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sim_ready_busy n=%0d busy %b exp 0", ng, busy); end
        $display("simultaneous: grant %0d to req %0d at cycle %0d", ng, ng % 2, c);
        last_id = req_ready[1];
        ng++;
      end
    end
    checks++; if (ng != 4) begin errors++; $display("FAIL sim_count got %0d grants exp 4", ng); end
    req_valid = '0;
    repeat (10) tick();
  endtask

  task automatic test_ready();
    int pulses;
    int pos [3];
    pulses = 0;
    req0_func = 7'o001; req0_data = 36'o7;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (req_ready !== 2'b00) begin
        checks++; if (busy !== 1'b0 || req_ready !== 2'b10) begin
          errors++; $display("FAIL ready_pulse c=%0d ready %b busy %b exp 10 0", c, req_ready, busy); end
        if (pulses < 3) pos[pulses] = c;
        pulses++;
      end
    end
    req_valid = '0;
    checks++; if (pulses != 3) begin errors++; $display("FAIL ready_count got %0d exp 3", pulses); end
    for (int i = 0; i < 3 && i < pulses; i++) begin
      checks++; if (pos[i] != 8 * i) begin errors++; $display("FAIL ready_pos n=%0d got %0d exp %0d", i, pos[i], 8 * i); end
    end
    $display("ready: %0d pulses over 20 cycles", pulses);
    repeat (10) tick();
  endtask

  task automatic test_async_reset();
    logic [0:1] g;
    bit saw_rsp;
    saw_rsp = 1'b0;
    req0_func = 7'o052; req0_data = 36'o1234; req_valid[0] = 1'b1;
    wait_ready(1'b0, g);
    checks++; if (g !== 2'b10) begin errors++; $display("FAIL arst_grant got %b exp 10", g); end
    req_valid = '0;
    repeat (3) tick();
    checks++; if (ebus_diag_strobe !== 1'b1) begin errors++; $display("FAIL arst_in_strobe got %b exp 1", ebus_diag_strobe); end
    reset = 1'b1;
    #1;
    checks++; if ({ebus_diag_strobe, ebus_data_oe} !== 2'b00 || ebus_ds !== 7'o000) begin
      errors++; $display("FAIL arst_drop got stb %b oe %b ds %o exp 0 0 000", ebus_diag_strobe, ebus_data_oe, ebus_ds); end
    if (rsp_valid) saw_rsp = 1'b1;
    tick();
    @(negedge clk) reset = 1'b0;
    req_valid = 2'b11;
    g = 2'b00;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
      if (req_ready !== 2'b00) begin g = req_ready; break; end
    end
    checks++; if (saw_rsp) begin errors++; $display("FAIL arst_no_rsp got rsp_valid 1 exp none"); end
    checks++; if (g !== 2'b10) begin errors++; $display("FAIL arst_next_grant got %b exp 10", g); end
    $display("async_reset: next grant %b", g);
    req_valid = '0;
    repeat (10) tick();
  endtask

  task automatic test_corner();
    logic [0:1] g;
    c_req1_func = 7'o000; c_req1_data = 36'o1; c_req_valid[1] = 1'b1;
    wait_ready(1'b1, g);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL corner_grant got %b exp 01", g); end
    c_req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (c_ebus_diag_strobe !== (k == 2)) begin errors++; $display("FAIL corner_strobe k=%0d got %b", k, c_ebus_diag_strobe); end
      checks++; if (c_rsp_valid !== (k == 3)) begin errors++; $display("FAIL corner_rsp_valid k=%0d got %b", k, c_rsp_valid); end
      checks++; if (c_ebus_data_oe !== (k <= 2)) begin errors++; $display("FAIL corner_oe k=%0d got %b", k, c_ebus_data_oe); end
      checks++; if (c_busy !== (k <= 3)) begin errors++; $display("FAIL corner_busy k=%0d got %b", k, c_busy); end
      if (k == 3) begin
        checks++; if (c_rsp_id !== 1'b1 || c_rsp_data !== 36'd0) begin
          errors++; $display("FAIL corner_rsp got id %b data %o exp 1 0", c_rsp_id, c_rsp_data); end
      end
    end
    $display("corner: func 000 id 1 latency 3");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_ready();
    test_async_reset();
    test_corner();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/diag_func_seq.md
Name: diag_func_seq

Overview:
- Diagnostic-function sequencer that drives the EBUS diagnostic lines (ds[0:6], data, diagStrobe) into the EBOX control board on behalf of two requesters.
- Requester 0 is the front-end console; requester 1 is the scripted self-test engine.
- Arbitrates requests round-robin and runs each as a timed setup/strobe/hold cycle.
- Write functions (ds[0]=0) drive EBUS data; read functions (ds[0]=1, codes 10x-17x) sample EBUS data at strobe end and return it to the requester.

Parameters:
SETUP_CYC, 2, clocks ds/data are stable before diagStrobe rises (1..15)
STROBE_CYC, 3, clocks diagStrobe is held high (1..15)
HOLD_CYC, 1, clocks ds/data are held after diagStrobe falls (0..15)

Ports:
clk  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high
req_valid  in  [0:1]  request pending, one bit per requester
req_ready  out  [0:1]  request accepted this cycle; one-hot or zero
req0_func  in  [0:6]  requester 0 diagnostic function code (ds[0:6])
req0_data  in  [0:35]  requester 0 write data
req1_func  in  [0:6]  requester 1 diagnostic function code
req1_data  in  [0:35]  requester 1 write data
rsp_valid  out  1  one-cycle response pulse
rsp_id  out  1  requester that owns the response
rsp_data  out  [0:35]  sampled read data; zero for write functions
ebus_ds  out  [0:6]  diagnostic select lines
ebus_data_out  out  [0:35]  EBUS data driven for write functions
ebus_data_oe  out  1  EBUS data output enable
ebus_diag_strobe  out  1  diagStrobe
ebus_data_in  in  [0:35]  EBUS data as seen on the bus
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async) values:
  - State is IDLE and the round-robin pointer is 0.
  - All outputs are 0. This includes ebus_ds=7'o000, ebus_data_oe=0 and ebus_diag_strobe=0.
  - Reset mid-cycle drops the strobe and the data enable immediately. The in-flight request gets no response.
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- A single 4-bit down-counter times SETUP, STROBE and HOLD.
- Arbitration in IDLE:
  - If exactly one req_valid bit is set, grant that requester.
  - If both are set, grant the requester the pointer selects. The pointer then flips to the other requester.
  - A single grant leaves the pointer pointing at the non-granted requester.
- On grant:
  - req_ready[id]=1 for exactly one cycle.
  - Latch func, data, id and is_read (func[0]).
  - Go to SETUP with count=SETUP_CYC-1.
  - Requesters must hold func/data valid only during the ready cycle.
- Output timing by state:
  - SETUP: ebus_ds=latched func. ebus_data_oe=~is_read and ebus_data_out=latched data. When count=0, go to STROBE with count=STROBE_CYC-1.
  - STROBE: ebus_diag_strobe=1, with ds/data unchanged. On the count=0 cycle, read functions capture ebus_data_in into the response register. Then go to HOLD with count=HOLD_CYC-1, or straight to RESP if HOLD_CYC=0.
  - HOLD: strobe is 0, ds/data held. When count=0, go to RESP.
  - RESP: rsp_valid=1 and rsp_id=latched id. rsp_data is the captured value for reads and 0 for writes. ebus_ds returns to 0 and oe to 0. Next state is IDLE.
- Latency from grant to rsp_valid is SETUP_CYC+STROBE_CYC+HOLD_CYC+1 clocks. With defaults this is 7.
- No request is accepted while busy. req_ready stays 0 outside IDLE.
- Back-to-back requests: the earliest next grant is the cycle after RESP. ds therefore returns to 0 for at least one clock between functions.
- Function code 7'o000 is legal and runs like any other write.
- All registers are outputs of flops. No combinational path exists from req_* or ebus_data_in to any output.

Decomposition:
- Shared package: diag_seq_state_t enum (IDLE, SETUP, STROBE, HOLD, RESP); constant DIAG_FUNC_W=7; EBUS_DATA_W=36.
- Sub-module rr_arb2 holds the round-robin pointer and grant logic, which keeps the arbitration testable on its own.

Test Plan:
- Write with defaults:
  - Stimulus: req0 func=7'o076, data bits 24:27=4'b1010.
  - Required: req_ready[0] in the grant cycle; ds=7'o076 and oe=1 for 6 clocks; strobe high in clocks 3-5; rsp_valid 7 clocks after grant with rsp_id=0 and rsp_data=0.
- Read:
  - Stimulus: req1 func=7'o100, ebus_data_in=36'o123456701234 during the last strobe clock.
  - Required: oe stays 0; rsp_id=1; rsp_data=36'o123456701234.
- Simultaneous requests from reset:
  - Stimulus: req0 and req1 both held valid.
  - Required: grants alternate 0,1,0,1; each grant occurs the cycle after the preceding RESP.
- Parameter corners:
  - Stimulus: SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=0.
  - Required: grant-to-rsp latency is 3; strobe is a single clock.
- Async reset mid-operation:
  - Stimulus: assert reset during STROBE.
  - Required: strobe, oe and ds go to 0 before the next clock edge; no rsp_valid occurs; the next grant after release goes to requester 0.
- Ready behaviour:
  - Stimulus: req0 held valid through a whole cycle.
  - Required: req_ready[0] pulses once per cycle and never while busy=1.
